// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_if
// Description : Handshake and data bundle between an ALU controller and the
//               sequential signed divider.
//               master : controller side (drives start/a/b)
//               slave  : divider side (drives busy/done/q/r/dbz/oflow)
//               start        request pulse, sampled only while idle
//               a, b         signed dividend / divisor
//               busy, done   operation in flight / one-cycle result strobe
//               q, r         signed quotient / remainder
//               dbz, oflow   divide-by-zero / quotient-overflow flags
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             dbz;
  logic             oflow;

  modport master (
    output start, a, b,
    input  busy, done, q, r, dbz, oflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, q, r, dbz, oflow
  );
endinterface
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle signed restoring divider, one quotient bit per
//               clock. Works on operand magnitudes, then applies sign
//               correction so the quotient truncates toward zero and the
//               remainder carries the sign of the dividend.
//               clk   rising-edge clock
//               rst   synchronous active-high reset
//               bus   seq_divider_if.slave (start/a/b in,
//                     busy/done/q/r/dbz/oflow out)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  seq_divider_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [WIDTH-1:0] c_min     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_neg_one = {WIDTH{1'b1}};

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] r_a;       // latched signed operands
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_dvd;     // |a| shifting out MSB-first, quotient bits shifting in
  logic [WIDTH-1:0] r_dvs;     // |b|
  logic [WIDTH-1:0] r_rem;     // partial remainder magnitude

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dbz;
  logic             r_oflow;

  logic             w_busy;
  logic             w_done;

  // Magnitudes as unsigned WIDTH-bit values: the most negative operand
  // negates to itself, which reads correctly as 2^(WIDTH-1) unsigned.
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  assign w_abs_a = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
  assign w_abs_b = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;

  // One restoring step. The partial remainder is always below |b| (at most
  // 2^(WIDTH-1)), so after a successful trial subtract the result fits in
  // WIDTH bits and modular WIDTH-bit subtraction is exact.
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  assign w_shift = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_sub   = w_shift[WIDTH-1:0] - r_dvs;

  logic w_neg_q;
  logic w_neg_r;
  logic w_ovf;
  assign w_neg_q = r_a[WIDTH-1] ^ r_b[WIDTH-1];
  assign w_neg_r = r_a[WIDTH-1];
  assign w_ovf   = (r_a == c_min) && (r_b == c_neg_one);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = (bus.b == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (r_cnt == '0) begin
          w_state_nxt = FIX;
        end
      end
      FIX:     w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode (state only, so no input reaches an output combinationally)
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      CALC, FIX: w_busy = 1'b1;
      DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // Datapath. Published results only move on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dbz   <= 1'b0;
      r_oflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_dvd <= w_abs_a;
            r_dvs <= w_abs_b;
            r_rem <= '0;
            r_cnt <= CNT_W'(WIDTH - 1);
            if (bus.b == '0) begin
              r_q     <= c_neg_one;
              r_r     <= bus.a;
              r_dbz   <= 1'b1;
              r_oflow <= 1'b0;
            end
          end
        end
        CALC: begin
          r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
          r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
        end
        FIX: begin
          // Overflow case wraps naturally: |q| = 2^(WIDTH-1), no negation.
          r_q     <= w_neg_q ? (~r_dvd + 1'b1) : r_dvd;
          r_r     <= w_neg_r ? (~r_rem + 1'b1) : r_rem;
          r_dbz   <= 1'b0;
          r_oflow <= w_ovf;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = w_busy;
  assign bus.done  = w_done;
  assign bus.q     = r_q;
  assign bus.r     = r_r;
  assign bus.dbz   = r_dbz;
  assign bus.oflow = r_oflow;

endmodule
`default_nettype wire
